// File: rtl/riscv_pkg.sv
// Constants and the fetch-queue entry type shared by the RV32I pipeline.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with wrap-bit pointers, synchronous reset and flush.
// The head entry is presented combinationally; an empty buffer presents zeros.
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = riscv_pkg::fetch_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        din,
  output entry_t        dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  entry_t        mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          empty_s;
  logic          full_s;
  logic          do_push_s;
  logic          do_pop_s;

  // Occupancy flags from the pointer pair: equal means empty, same index with
  // opposite wrap bit means full.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  end

  // Qualify requests: flush cancels both, a pop needs data, a push into a full
  // buffer is only legal when the head is leaving in the same cycle.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end else begin
      do_pop_s  = pop & ~empty_s;
      do_push_s = push & (~full_s | do_pop_s);
    end
  end

  // Pointer update; flush and reset both return the buffer to empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Entry storage; contents of unoccupied slots are never presented, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Head entry, forced to zero while empty.
  always_comb begin
    dout = '0;
    if (empty_s) begin
      dout = '0;
    end else begin
      dout = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  assign empty = empty_s;
  assign full  = full_s;
  assign count = CW'(wr_ptr_r - rd_ptr_r);

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, fills a prefetch queue from
// the combinational imem and hands queued {PC, Instr} pairs to Decode.
// A redirect from Execute flushes the queue and restarts fetch at the target.
module fetch_queue_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  localparam int             CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] PCF,
  input  logic [31:0]     InstrF,
  input  logic            RedirectE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ValidD,
  input  logic            ReadyD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic [CW-1:0]   Count
);

  import riscv_pkg::*;

  // XLEN must agree with the package, since queue entries use its entry type.

  logic [XLEN-1:0] pc_r;
  logic            push_s;
  logic            pop_s;
  logic            empty_s;
  logic            full_s;
  fetch_entry_t    din_s;
  fetch_entry_t    head_s;
  logic [CW-1:0]   count_s;

  // Handshake: Decode takes the head when valid and ready; fetch pushes unless
  // redirected or the queue is full with nothing leaving.
  always_comb begin
    pop_s  = ~empty_s & ReadyD;
    push_s = ~RedirectE & (~full_s | pop_s);
  end

  // Entry written at the tail is the current fetch address and its word.
  always_comb begin
    din_s       = '0;
    din_s.pc    = pc_r;
    din_s.instr = InstrF;
  end

  // Fetch PC: reset beats redirect beats sequential advance; otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (RedirectE) begin
      pc_r <= {PCTargetE[XLEN-1:2], 2'b00};
    end else if (push_s) begin
      pc_r <= pc_r + XLEN'(4);
    end else begin
      pc_r <= pc_r;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .flush (RedirectE),
    .din   (din_s),
    .dout  (head_s),
    .empty (empty_s),
    .full  (full_s),
    .count (count_s)
  );

  // Head presentation to Decode; the +4 is derived from the stored PC and is
  // zero along with everything else when the queue is empty.
  always_comb begin
    ValidD   = ~empty_s;
    InstrD   = head_s.instr;
    PCD      = head_s.pc;
    PCPlus4D = '0;
    if (empty_s) begin
      PCPlus4D = '0;
    end else begin
      PCPlus4D = head_s.pc + XLEN'(4);
    end
  end

  assign PCF   = pc_r;
  assign Count = count_s;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a main instance at RESET_PC = 0 and a
// second instance starting near the top of the address space.
module tb_fetch_queue_unit;

  logic        clk;
  logic        reset;
  logic        redirect_e;
  logic [31:0] pc_target_e;
  logic        ready_d;

  logic [31:0] pcf;
  logic [31:0] instr_f;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pcd;
  logic [31:0] pcp4d;
  logic [2:0]  count;

  logic        redirect_w;
  logic [31:0] target_w;
  logic        ready_w;
  logic [31:0] pcf_w;
  logic [31:0] instr_f_w;
  logic        valid_w;
  logic [31:0] instr_d_w;
  logic [31:0] pcd_w;
  logic [31:0] pcp4d_w;
  logic [2:0]  count_w;

  int n_assert;
  int n_fail;

  function automatic logic [31:0] tag(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  assign instr_f   = tag(pcf);
  assign instr_f_w = tag(pcf_w);

  fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PCF(pcf), .InstrF(instr_f),
    .RedirectE(redirect_e), .PCTargetE(pc_target_e),
    .ValidD(valid_d), .ReadyD(ready_d), .InstrD(instr_d),
    .PCD(pcd), .PCPlus4D(pcp4d), .Count(count)
  );

  fetch_queue_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .PCF(pcf_w), .InstrF(instr_f_w),
    .RedirectE(redirect_w), .PCTargetE(target_w),
    .ValidD(valid_w), .ReadyD(ready_w), .InstrD(instr_d_w),
    .PCD(pcd_w), .PCPlus4D(pcp4d_w), .Count(count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Outputs depend only on state, so checking and driving both happen on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    redirect_e  = 1'b0;
    pc_target_e = 32'h0;
    ready_d     = 1'b1;
    redirect_w  = 1'b0;
    target_w    = 32'h0;
    ready_w     = 1'b1;

    // Reset state
    cyc(); cyc();
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_pcf",   pcf,          32'h0);
    chk("rst_count", 32'(count),   32'd0);
    chk("rst_pcd",   pcd,          32'h0);
    chk("rst_instr", instr_d,      32'h0);
    chk("rst_pcp4",  pcp4d,        32'h0);
    chk("rst_pcf_w", pcf_w,        32'hFFFF_FFF8);
    reset = 1'b0;

    // Streaming with Decode always ready; wrap instance runs alongside
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("str_valid", 32'(valid_d), 32'd1);
      chk("str_pcd",   pcd,          32'(i * 4));
      chk("str_pcp4",  pcp4d,        32'(i * 4 + 4));
      chk("str_instr", instr_d,      tag(32'(i * 4)));
      chk("str_count", 32'(count),   32'd1);
      if (i == 0) begin
        chk("wrap_pcd0", pcd_w, 32'hFFFF_FFF8);
      end else if (i == 1) begin
        chk("wrap_pcd1",  pcd_w,   32'hFFFF_FFFC);
        chk("wrap_pcp41", pcp4d_w, 32'h0000_0000);
      end else if (i == 2) begin
        chk("wrap_pcd2", pcd_w, 32'h0000_0000);
      end else begin
        chk("wrap_pcd3", pcd_w, 32'h0000_0004);
      end
    end

    // Stall: fresh reset, Decode not ready for 10 cycles
    reset   = 1'b1;
    ready_d = 1'b0;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("stall_count", 32'(count), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    chk("stall_pcf", pcf, 32'h10);
    chk("stall_pcd", pcd, 32'h0);
    ready_d = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("drain_pcd",   pcd,          32'(i * 4));
      chk("drain_valid", 32'(valid_d), 32'd1);
      chk("drain_count", 32'(count),   32'd4);
    end

    // Redirect while Count = 3 with a pop in the same cycle
    reset   = 1'b1;
    ready_d = 1'b0;
    cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    chk("pre_redir_count", 32'(count), 32'd3);
    redirect_e  = 1'b1;
    pc_target_e = 32'h40;
    ready_d     = 1'b1;
    cyc();
    chk("redir_valid", 32'(valid_d), 32'd0);
    chk("redir_count", 32'(count),   32'd0);
    chk("redir_pcf",   pcf,          32'h40);
    redirect_e = 1'b0;
    cyc();
    chk("redir_pcd",   pcd,          32'h40);
    chk("redir_valid2", 32'(valid_d), 32'd1);

    // Misaligned redirect target
    redirect_e  = 1'b1;
    pc_target_e = 32'h47;
    cyc();
    chk("misal_pcf",   pcf,          32'h44);
    chk("misal_valid", 32'(valid_d), 32'd0);

    // Two consecutive redirects: 0x80 then 0x100
    pc_target_e = 32'h80;
    cyc();
    chk("b2b_pcf1",   pcf,          32'h80);
    chk("b2b_valid1", 32'(valid_d), 32'd0);
    pc_target_e = 32'h100;
    cyc();
    chk("b2b_pcf2",   pcf,          32'h100);
    chk("b2b_valid2", 32'(valid_d), 32'd0);
    redirect_e = 1'b0;
    cyc();
    chk("b2b_pcd1", pcd, 32'h100);
    chk("b2b_cnt1", 32'(count), 32'd1);
    cyc();
    chk("b2b_pcd2", pcd, 32'h104);

    // Reset while Count = 2
    ready_d = 1'b0;
    cyc();
    chk("prerst_count", 32'(count), 32'd2);
    reset = 1'b1;
    cyc();
    chk("midrst_valid", 32'(valid_d), 32'd0);
    chk("midrst_pcf",   pcf,          32'h0);
    chk("midrst_count", 32'(count),   32'd0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
